// File: rtl/txn_arbiter.sv
// Round-robin transaction arbiter. It grants one requester at a time and
// presents that requester's item to a downstream driver. It then waits for
// item_done, or for a timeout. A requester can hold the grant across
// consecutive items with req_lock.

// Per-requester qualification: decides whether this requester may win, and
// decodes its one-hot ready bit from the shared winner index.
module txn_arbiter_lane #(
  parameter int IDW = 2,
  parameter int IDX = 0
) (
  input  logic           valid,
  input  logic           lock_active,
  input  logic [IDW-1:0] lock_owner,
  input  logic           grant_en,
  input  logic [IDW-1:0] winner,
  output logic           eligible,
  output logic           ready
);
  // While a lock is held, only the owner is eligible.
  assign eligible = valid & (~lock_active | (lock_owner == IDW'(IDX)));
  assign ready    = grant_en & (winner == IDW'(IDX));
endmodule

module txn_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_lock,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [$clog2(NUM_REQ)-1:0]    out_id,
  input  logic                          out_ready,
  input  logic                          item_done,
  output logic                          timeout_err,
  output logic                          busy
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t               state, state_nxt;
  logic [IDW-1:0]       rr_ptr;
  logic [IDW-1:0]       lock_owner;
  logic                 locked;
  logic [CW-1:0]        cnt;
  logic [NUM_REQ-1:0]   eligible;
  logic [IDW-1:0]       winner;
  logic                 win_found;
  logic                 lock_active;
  logic                 grant_en;
  logic                 expire;
  logic [IDW-1:0]       nxt_ptr;

  // A lock is honoured only while its owner keeps req_lock high. Once the
  // owner drops req_lock, ordinary round-robin applies in that same cycle.
  assign lock_active = locked & req_lock[lock_owner];
  assign grant_en    = (state == S_IDLE) & win_found & ~rst;
  assign expire      = (cnt == CW'(TIMEOUT_CYCLES - 1));
  assign nxt_ptr     = (out_id == IDW'(NUM_REQ - 1)) ? '0 : out_id + IDW'(1);

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    txn_arbiter_lane #(.IDW(IDW), .IDX(i)) u_lane (
      .valid       (req_valid[i]),
      .lock_active (lock_active),
      .lock_owner  (lock_owner),
      .grant_en    (grant_en),
      .winner      (winner),
      .eligible    (eligible[i]),
      .ready       (req_ready[i])
    );
  end

  // Find the first eligible requester, searching upward from rr_ptr and wrapping.
  always_comb begin
    int idx;
    idx       = 0;
    winner    = '0;
    win_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!win_found && eligible[idx]) begin
        winner    = IDW'(idx);
        win_found = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic. item_done wins over expiry on the last WAIT cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (win_found)            state_nxt = S_ISSUE;
      S_ISSUE: if (out_ready)            state_nxt = S_WAIT;
      S_WAIT:  if (item_done || expire)  state_nxt = S_IDLE;
      default:                           state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state; req_ready comes from the lane instances.
  always_comb begin
    out_valid = (state == S_ISSUE);
    busy      = (state != S_IDLE);
  end

  // Payload capture, round-robin pointer, lock bookkeeping, WAIT counter and
  // timeout pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data    <= '0;
      out_id      <= '0;
      rr_ptr      <= '0;
      locked      <= 1'b0;
      lock_owner  <= '0;
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (locked && !req_lock[lock_owner]) locked <= 1'b0;
          if (win_found) begin
            out_data <= req_data[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
            out_id   <= winner;
          end
        end
        S_ISSUE: cnt <= '0;
        S_WAIT: begin
          if (item_done) begin
            cnt    <= '0;
            rr_ptr <= nxt_ptr;
            locked <= req_lock[out_id];
            if (req_lock[out_id]) lock_owner <= out_id;
          end else if (expire) begin
            cnt         <= '0;
            rr_ptr      <= nxt_ptr;
            locked      <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: cnt <= '0;
      endcase
    end
  end
endmodule

// File: tb/tb_txn_arbiter.sv
// Bench for txn_arbiter: table of arbitration vectors, hand-written corner
// sequences, then random traffic against a transaction-level reference model.
module tb_txn_arbiter;
  localparam int NR = 4;
  localparam int DW = 32;
  localparam int TO = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid, req_lock, req_ready;
  logic [NR*DW-1:0]  req_data;
  logic              out_valid;
  logic [DW-1:0]     out_data;
  logic [1:0]        out_id;
  logic              out_ready, item_done, timeout_err, busy;

  int vectors = 0;
  int miscompares = 0;

  txn_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_lock(req_lock), .req_ready(req_ready), .out_valid(out_valid),
    .out_data(out_data), .out_id(out_id), .out_ready(out_ready),
    .item_done(item_done), .timeout_err(timeout_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] prior;     // single-bit grant done first to move rr_ptr; 0 = none
    int         prior_id;
    logic [3:0] valid;
    int         exp_id;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] pat(input int i);
    return (i == 2) ? 32'hDEADBEEF : 32'hC0DE0000 + 32'(i);
  endfunction

  task automatic load_pattern;
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = pat(i);
  endtask

  task automatic do_reset;
    rst = 1'b1; req_valid = '1; req_lock = '0; out_ready = 1'b0; item_done = 1'b0;
    #1;
    chk("rst_ready_gated", 64'(req_ready), 64'd0);
    tick; tick;
    rst = 1'b0;
  endtask

  // Grant exp_id, hold out_ready low for 'stall' ISSUE cycles, then move to WAIT_DONE.
  task automatic start_item(input logic [3:0] v, input logic [3:0] lk, input int exp_id, input int stall);
    req_valid = v; req_lock = lk; out_ready = 1'b0; item_done = 1'b0;
    #1;
    chk("grant_ready", 64'(req_ready), 64'd1 << exp_id);
    tick;
    chk("issue_valid", 64'(out_valid), 64'd1);
    chk("issue_id", 64'(out_id), 64'(exp_id));
    chk("issue_data", 64'(out_data), 64'(pat(exp_id)));
    chk("issue_ready_low", 64'(req_ready), 64'd0);
    for (int s = 0; s < stall; s++) begin
      tick;
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_data", 64'(out_data), 64'(pat(exp_id)));
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk("wait_valid", 64'(out_valid), 64'd0);
    chk("wait_busy", 64'(busy), 64'd1);
  endtask

  task automatic finish_item;
    item_done = 1'b1;
    tick;
    item_done = 1'b0;
    chk("done_idle", 64'(busy), 64'd0);
    chk("done_noerr", 64'(timeout_err), 64'd0);
  endtask

  // Reference model state (transaction level)
  int         m_phase, m_rr, m_owner, m_cur, m_wait;
  bit         m_locked, m_terr;
  logic [DW-1:0] m_data;

  function automatic int m_pick;
    if (m_locked && req_lock[m_owner]) return req_valid[m_owner] ? m_owner : -1;
    for (int k = 0; k < NR; k++)
      if (req_valid[(m_rr + k) % NR]) return (m_rr + k) % NR;
    return -1;
  endfunction

  task automatic m_step;
    int w;
    w = m_pick();
    if (rst) begin
      m_phase = 0; m_rr = 0; m_owner = 0; m_cur = 0; m_wait = 0;
      m_locked = 0; m_terr = 0; m_data = '0;
      return;
    end
    m_terr = 0;
    case (m_phase)
      0: begin
        if (m_locked && !req_lock[m_owner]) m_locked = 0;
        if (w >= 0) begin m_cur = w; m_data = req_data[w*DW +: DW]; m_phase = 1; end
      end
      1: if (out_ready) begin m_phase = 2; m_wait = 0; end
      default: begin
        if (item_done) begin
          m_rr = (m_cur + 1) % NR;
          m_locked = req_lock[m_cur];
          if (req_lock[m_cur]) m_owner = m_cur;
          m_phase = 0;
        end else if (m_wait == TO - 1) begin
          m_terr = 1; m_locked = 0; m_rr = (m_cur + 1) % NR; m_phase = 0;
        end else m_wait++;
      end
    endcase
  endtask

  initial begin
    vec_t vt[8];
    int first, pulses, w;
    logic [NR-1:0] exp_rdy;
    vt[0] = '{4'b0000, 0, 4'b0001, 0};
    vt[1] = '{4'b0000, 0, 4'b1000, 3};
    vt[2] = '{4'b0000, 0, 4'b0110, 1};
    vt[3] = '{4'b0000, 0, 4'b1111, 0};
    vt[4] = '{4'b0001, 0, 4'b0001, 0};
    vt[5] = '{4'b0100, 2, 4'b0011, 0};
    vt[6] = '{4'b1000, 3, 4'b1010, 1};
    vt[7] = '{4'b0010, 1, 4'b0011, 0};
    req_data = '0;
    load_pattern();

    // Reset state
    do_reset();
    req_valid = '0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_id", 64'(out_id), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_terr", 64'(timeout_err), 64'd0);

    // Arbitration table
    for (int t = 0; t < 8; t++) begin
      do_reset();
      if (vt[t].prior != 4'b0000) begin
        start_item(vt[t].prior, 4'b0000, vt[t].prior_id, 0);
        finish_item();
      end
      start_item(vt[t].valid, 4'b0000, vt[t].exp_id, 0);
      finish_item();
    end

    // Fairness: 0,1,2,3,0
    do_reset();
    for (int k = 0; k < 5; k++) begin
      start_item(4'b1111, 4'b0000, k % 4, 0);
      finish_item();
    end

    // Backpressure on requester 2
    do_reset();
    start_item(4'b0100, 4'b0000, 2, 5);
    finish_item();

    // Lock by requester 1
    do_reset();
    start_item(4'b0001, 4'b0000, 0, 0); finish_item();
    start_item(4'b1011, 4'b0010, 1, 0); finish_item();
    start_item(4'b1011, 4'b0010, 1, 0); finish_item();
    req_valid = 4'b1001; req_lock = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("lock_hold_ready", 64'(req_ready), 64'd0);
      tick;
      chk("lock_hold_busy", 64'(busy), 64'd0);
    end
    start_item(4'b1011, 4'b0010, 1, 0); finish_item();
    start_item(4'b1011, 4'b0000, 3, 0); finish_item();
    start_item(4'b1011, 4'b0000, 0, 0); finish_item();

    // Timeout
    do_reset();
    start_item(4'b0100, 4'b0000, 2, 0);
    req_valid = '0;
    first = 0; pulses = 0;
    for (int k = 1; k <= 12; k++) begin
      tick;
      if (timeout_err) begin
        pulses++;
        if (first == 0) first = k;
      end
    end
    chk("timeout_cycle", 64'(first), 64'd8);
    chk("timeout_pulses", 64'(pulses), 64'd1);
    chk("timeout_idle", 64'(busy), 64'd0);
    start_item(4'b1111, 4'b0000, 3, 0); finish_item();

    // item_done together with out_ready in ISSUE is ignored
    do_reset();
    req_valid = 4'b0010; req_lock = '0;
    tick;
    out_ready = 1'b1; item_done = 1'b1;
    tick;
    out_ready = 1'b0; item_done = 1'b0;
    chk("simul_wait_busy", 64'(busy), 64'd1);
    chk("simul_wait_valid", 64'(out_valid), 64'd0);
    tick; tick;
    chk("simul_still_wait", 64'(busy), 64'd1);
    finish_item();

    // item_done on the expiry cycle beats the timeout
    do_reset();
    start_item(4'b0001, 4'b0000, 0, 0);
    req_valid = '0;
    for (int k = 0; k < 7; k++) tick;
    chk("expiry_still_wait", 64'(busy), 64'd1);
    item_done = 1'b1;
    tick;
    item_done = 1'b0;
    chk("expiry_noerr", 64'(timeout_err), 64'd0);
    chk("expiry_idle", 64'(busy), 64'd0);
    tick;
    chk("expiry_noerr_late", 64'(timeout_err), 64'd0);
    start_item(4'b1111, 4'b0000, 1, 0); finish_item();

    // Mid-operation reset while locked
    do_reset();
    start_item(4'b0100, 4'b0100, 2, 0); finish_item();
    start_item(4'b0100, 4'b0100, 2, 0);
    rst = 1'b1;
    tick;
    chk("mrst_ready", 64'(req_ready), 64'd0);
    chk("mrst_valid", 64'(out_valid), 64'd0);
    chk("mrst_data", 64'(out_data), 64'd0);
    chk("mrst_id", 64'(out_id), 64'd0);
    chk("mrst_terr", 64'(timeout_err), 64'd0);
    chk("mrst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    start_item(4'b1111, 4'b0100, 0, 0); finish_item();

    // Random traffic against the reference model
    do_reset();
    rst = 1'b1;
    m_step();
    tick;
    rst = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      rst       = ($urandom % 150) == 0;
      req_valid = NR'($urandom);
      req_lock  = NR'($urandom & $urandom);
      for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = $urandom;
      out_ready = ($urandom % 3) != 0;
      item_done = ($urandom % 5) == 0;
      #1;
      w = m_pick();
      exp_rdy = (m_phase == 0 && !rst && w >= 0) ? NR'(1) << w : '0;
      chk("rnd_ready", 64'(req_ready), 64'(exp_rdy));
      chk("rnd_valid", 64'(out_valid), 64'(m_phase == 1));
      chk("rnd_busy", 64'(busy), 64'(m_phase != 0));
      chk("rnd_terr", 64'(timeout_err), 64'(m_terr));
      chk("rnd_id", 64'(out_id), 64'(m_cur));
      chk("rnd_data", 64'(out_data), 64'(m_data));
      m_step();
      tick;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
